branch_resolve_bht: RTL and testbench

EX-stage branch resolution unit with a direct-mapped branch target/history table. It consumes the branch controls and prediction bit leaving the ID/EX pipeline register (B, J, JR, predicted-taken, PC) plus the EX comparator outcome, and decides mispredictions. On a misprediction it drives the flush (`clear_u`) and redirect PC back into fetch and the ID/EX register. It also serves the IF-stage lookup that produces the prediction bit carried down the pipe, and keeps saturating branch and mispredict statistics.

---
 rtl/branch_resolve_bht.sv | 101 ++++++++++
 tb/tb_branch_resolve_bht.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_bht.sv
`default_nettype none
// ============================================================================
// branch_resolve_bht : EX-stage branch resolution with direct-mapped BTB/BHT
// Revision: 1.0
// ============================================================================
module branch_resolve_bht #(
   parameter int IDX_BITS = 3,
   parameter int STAT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic [31:0]       if_pc,
   output logic              pred_taken,
   output logic [31:0]       pred_target,
   input  logic [31:0]       ex_pc,
   input  logic              ex_B,
   input  logic              ex_J,
   input  logic              ex_JR,
   input  logic              ex_pred,
   input  logic [31:0]       ex_pred_target,
   input  logic              ex_cond,
   input  logic [31:0]       ex_target,
   output logic              clear_u,
   output logic [31:0]       redirect_pc,
   output logic [STAT_W-1:0] br_cnt,
   output logic [STAT_W-1:0] miss_cnt
);

   localparam int ENTRIES = 1 << IDX_BITS;
   localparam int TAG_W   = 32 - IDX_BITS - 2;

   logic                valid  [ENTRIES];
   logic [TAG_W-1:0]    tag    [ENTRIES];
   logic [31:0]         target [ENTRIES];
   logic [1:0]          ctr    [ENTRIES];

   logic [IDX_BITS-1:0] if_idx;
   logic [TAG_W-1:0]    if_tag;
   logic                if_hit;
   logic [IDX_BITS-1:0] ex_idx;
   logic [TAG_W-1:0]    ex_tag;
   logic                ex_hit;
   logic                resolve;
   logic                actual;
   logic                mispredict;
   logic                update;
   logic                unused_pc_bits;

   // Word-aligned PCs: the low two bits never index or tag the table.
   assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

   assign if_idx      = if_pc[IDX_BITS+1:2];
   assign if_tag      = if_pc[31:IDX_BITS+2];
   assign if_hit      = valid[if_idx] && (tag[if_idx] == if_tag);
   assign pred_taken  = if_hit && ctr[if_idx][1];
   assign pred_target = if_hit ? target[if_idx] : 32'd0;

   assign ex_idx     = ex_pc[IDX_BITS+1:2];
   assign ex_tag     = ex_pc[31:IDX_BITS+2];
   assign ex_hit     = valid[ex_idx] && (tag[ex_idx] == ex_tag);
   assign resolve    = ex_B | ex_J | ex_JR;
   assign actual     = ex_J | ex_JR | (ex_B & ex_cond);
   // A taken prediction with the wrong target is as bad as a wrong direction.
   assign mispredict = resolve & ((actual != ex_pred) |
                                  (actual & ex_pred & (ex_pred_target != ex_target)));
   assign clear_u     = mispredict & run;
   assign redirect_pc = actual ? ex_target : ex_pc + 32'd4;
   assign update      = resolve & run;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid[i]  <= 1'b0;
            tag[i]    <= '0;
            target[i] <= 32'd0;
            ctr[i]    <= 2'd0;
         end
         br_cnt   <= '0;
         miss_cnt <= '0;
      end else if (update) begin
         if (ex_hit) begin
            if (actual) begin
               if (ctr[ex_idx] != 2'd3) ctr[ex_idx] <= ctr[ex_idx] + 2'd1;
               target[ex_idx] <= ex_target;
            end else if (ctr[ex_idx] != 2'd0) begin
               ctr[ex_idx] <= ctr[ex_idx] - 2'd1;
            end
         end else if (actual) begin
            valid[ex_idx]  <= 1'b1;
            tag[ex_idx]    <= ex_tag;
            target[ex_idx] <= ex_target;
            ctr[ex_idx]    <= 2'd2;
         end
         if (br_cnt != '1) br_cnt <= br_cnt + 1'b1;
         if (mispredict && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_bht.sv
`default_nettype none
// ============================================================================
// tb_branch_resolve_bht : directed self-checking bench for branch_resolve_bht
// Revision: 1.0
// ============================================================================
module tb_branch_resolve_bht;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic [31:0] ex_pc;
   logic        ex_B, ex_J, ex_JR, ex_pred, ex_cond;
   logic [31:0] ex_pred_target, ex_target;
   logic        clear_u;
   logic [31:0] redirect_pc;
   logic [15:0] br_cnt, miss_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   branch_resolve_bht #(.IDX_BITS(3), .STAT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
      .ex_pc(ex_pc), .ex_B(ex_B), .ex_J(ex_J), .ex_JR(ex_JR),
      .ex_pred(ex_pred), .ex_pred_target(ex_pred_target),
      .ex_cond(ex_cond), .ex_target(ex_target),
      .clear_u(clear_u), .redirect_pc(redirect_pc),
      .br_cnt(br_cnt), .miss_cnt(miss_cnt)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; comparisons follow a further #1.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic b, input logic j, input logic jr, input logic [31:0] pc,
                        input logic cond, input logic pred, input logic [31:0] ptgt,
                        input logic [31:0] tgt);
      ex_B = b; ex_J = j; ex_JR = jr; ex_pc = pc; ex_cond = cond;
      ex_pred = pred; ex_pred_target = ptgt; ex_target = tgt;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic lookup(input string name, input logic [31:0] pc,
                         input logic exp_taken, input logic [31:0] exp_tgt);
      if_pc = pc;
      #1;
      check({name, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_taken});
      check({name, "_target"}, pred_target, exp_tgt);
   endtask

   task automatic counts(input string name, input logic [15:0] b, input logic [15:0] m);
      check({name, "_br"}, {16'd0, br_cnt}, {16'd0, b});
      check({name, "_miss"}, {16'd0, miss_cnt}, {16'd0, m});
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; if_pc = 32'h40;
      drive(1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
      lookup("rst_lookup", 32'h40, 1'b0, 32'h0);
      counts("rst", 16'd0, 16'd0);
      check("idle_clear", {31'd0, clear_u}, 32'd0);
      check("idle_redirect", redirect_pc, 32'h14);
      step();
      rst_n = 1'b1; run = 1'b1;

      // First taken branch: mispredict and allocation
      drive(1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0, 32'h0, 32'h80);
      check("alloc_clear", {31'd0, clear_u}, 32'd1);
      check("alloc_redirect", redirect_pc, 32'h80);
      lookup("alloc_pre", 32'h40, 1'b0, 32'h0);
      step(); idle();
      lookup("alloc_post", 32'h40, 1'b1, 32'h80);
      counts("alloc", 16'd1, 16'd1);

      // Not-taken with taken prediction: ctr 2 -> 1
      drive(1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 1'b1, 32'h80, 32'h80);
      check("nt1_clear", {31'd0, clear_u}, 32'd1);
      check("nt1_redirect", redirect_pc, 32'h44);
      step(); idle();
      lookup("nt1", 32'h40, 1'b0, 32'h80);
      drive(1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h80);
      check("nt2_clear", {31'd0, clear_u}, 32'd0);
      step(); idle();
      lookup("nt2", 32'h40, 1'b0, 32'h80);
      counts("nt2", 16'd3, 16'd2);

      // Four taken: ctr 0 -> 1 -> 2 -> 3 -> 3
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b0, 1'b0, 32'h40, 1'b1, (k >= 2), (k >= 2) ? 32'h80 : 32'h0, 32'h80);
         step(); idle();
         if_pc = 32'h40; #1;
         check("tk_taken", {31'd0, pred_taken}, {31'd0, (k >= 1)});
      end
      counts("tk", 16'd7, 16'd4);
      drive(1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 1'b1, 32'h80, 32'h80);
      step(); idle();
      lookup("sat_nt", 32'h40, 1'b1, 32'h80);
      counts("sat_nt", 16'd8, 16'd5);

      // Aliasing on index 0
      lookup("alias_pre", 32'h60, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h60, 1'b1, 1'b0, 32'h0, 32'hA0);
      step(); idle();
      lookup("alias_new", 32'h60, 1'b1, 32'hA0);
      lookup("alias_old", 32'h40, 1'b0, 32'h0);
      counts("alias", 16'd9, 16'd6);

      // JR target mismatch, then match
      drive(1'b0, 1'b0, 1'b1, 32'h60, 1'b0, 1'b1, 32'h100, 32'h200);
      check("jr_clear", {31'd0, clear_u}, 32'd1);
      check("jr_redirect", redirect_pc, 32'h200);
      step(); idle();
      lookup("jr_upd", 32'h60, 1'b1, 32'h200);
      drive(1'b0, 1'b0, 1'b1, 32'h60, 1'b0, 1'b1, 32'h200, 32'h200);
      check("jr_match_clear", {31'd0, clear_u}, 32'd0);
      step(); idle();
      counts("jr", 16'd11, 16'd7);

      // Stall then release
      run = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 1'b0, 32'h0, 32'h300);
      check("stall_clear", {31'd0, clear_u}, 32'd0);
      step();
      counts("stall", 16'd11, 16'd7);
      lookup("stall", 32'h20, 1'b0, 32'h0);
      run = 1'b1; #1;
      check("release_clear", {31'd0, clear_u}, 32'd1);
      check("release_redirect", redirect_pc, 32'h300);
      step(); idle();
      lookup("release", 32'h20, 1'b1, 32'h300);
      counts("release", 16'd12, 16'd8);

      // Asynchronous reset mid-cycle with an update pending
      drive(1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 1'b0, 32'h0, 32'h300);
      #1 rst_n = 1'b0; #1;
      lookup("areset", 32'h20, 1'b0, 32'h0);
      counts("areset", 16'd0, 16'd0);
      step();
      counts("areset_hold", 16'd0, 16'd0);
      idle();
      rst_n = 1'b1;
      step();

      // Statistics saturation with correctly predicted jumps
      drive(1'b0, 1'b1, 1'b0, 32'h4, 1'b0, 1'b1, 32'h8, 32'h8);
      check("sat_clear", {31'd0, clear_u}, 32'd0);
      for (int k = 0; k < 65540; k++) @(posedge clk);
      #1;
      counts("sat", 16'hFFFF, 16'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
